// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time. It synchronises
//   and debounces the column reads and reports each accepted key press once.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   col[3:0]   keypad columns, active-low, pulled up
//   row[3:0]   keypad rows, one-hot active-low (driven row = 0)
//   key_code   last accepted key, {row_idx, col_idx}
//   key_valid  one-cycle pulse when a new key is accepted
//   key_held   high while the accepted key remains pressed
//
// Parameters
//   SCAN_DIV   cycles each row is driven before its columns are sampled (>= 4)
//   DEBOUNCE   consecutive identical samples to accept a press/release (>= 2)

module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t        state, state_next;
  logic [3:0]    col_m, col_s;
  logic [DW-1:0] dwell;
  logic [1:0]    row_idx, row_idx_next;
  logic [3:0]    cand, cand_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]    key_code_next;
  logic          key_valid_next, key_held_next;
  logic          sample, hit;
  logic [1:0]    col_idx;
  logic [3:0]    code;

  // Two-flop synchroniser for the asynchronous keypad columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  // Free-running dwell counter. A row change always lands on the cycle after
  // a sample, so each row is driven from dwell = 0. The sample at
  // SCAN_DIV-1 therefore sees a col_s that has settled through the
  // synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
    end else if (dwell == DWELL_LAST) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Only a single closed column counts as a hit. Multi-key presses fall
  // into the default branch and are treated as a miss.
  always_comb begin
    hit     = 1'b1;
    col_idx = 2'd0;
    case (col_s)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  assign sample  = (dwell == DWELL_LAST);
  assign code    = {row_idx, col_idx};
  assign cnt_inc = cnt + 1'b1;

  // Next-state logic. The FSM only acts on sample cycles. cnt serves as the
  // press counter in ST_DEBOUNCE and as the release counter in ST_HELD.
  always_comb begin
    state_next     = state;
    row_idx_next   = row_idx;
    cand_next      = cand;
    cnt_next       = cnt;
    key_code_next  = key_code;
    key_valid_next = 1'b0;
    key_held_next  = key_held;
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (hit) begin
            cand_next  = code;
            cnt_next   = CW'(1);
            state_next = ST_DEBOUNCE;
          end else begin
            row_idx_next = row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (hit && (code == cand)) begin
            if (cnt_inc == CNT_DONE) begin
              key_code_next  = cand;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              cnt_next       = '0;
              state_next     = ST_HELD;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cnt_next     = '0;
            row_idx_next = row_idx + 2'd1;
            state_next   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (hit) begin
            cnt_next = '0;
          end else if (cnt_inc == CNT_DONE) begin
            key_held_next = 1'b0;
            cnt_next      = '0;
            row_idx_next  = row_idx + 2'd1;
            state_next    = ST_SCAN;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          cnt_next   = '0;
          state_next = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      cand      <= 4'h0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      row_idx   <= row_idx_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
      key_held  <= key_held_next;
    end
  end

  assign row = ~(4'b0001 << row_idx);

endmodule
